// File: rtl/inst_fetch_unit.sv
// Instruction fetch: accepts PC, issues one outstanding imem request, and buffers
// {inst, pc, err} in a small FIFO for decode. Flush drops buffered and in-flight fetches.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DATA_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_err_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state, state_nxt;
  logic               kill_q, kill_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  fifo_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [FIFO_DEPTH];
  logic               fifo_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               pc_ready_int;
  logic               req_valid_int;
  logic               latch_addr;
  logic               push, pop;
  logic [DATA_W-1:0]  push_inst;
  logic [ADDR_W-1:0]  push_pc;
  logic               push_err;
  logic [CNT_W:0]     credit;
  logic               head_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      kill_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      kill_q <= kill_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    kill_nxt      = kill_q;
    pc_ready_int  = 1'b0;
    req_valid_int = 1'b0;
    latch_addr    = 1'b0;
    push          = 1'b0;
    push_inst     = '0;
    push_pc       = pc_i;
    push_err      = 1'b0;
    credit        = {1'b0, count} + {{CNT_W{1'b0}}, (state != IDLE)};
    case (state)
      IDLE: begin
        pc_ready_int = !flush_i && (credit < DEPTH_C);
        if (pc_valid_i && pc_ready_int) begin
          if (pc_i[1:0] != 2'b00) begin
            push     = 1'b1;
            push_err = 1'b1;
          end else begin
            latch_addr = 1'b1;
            state_nxt  = REQ;
          end
        end
      end
      REQ: begin
        req_valid_int = 1'b1;
        if (flush_i) kill_nxt = 1'b1;
        if (imem_req_ready_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          push      = !kill_q;
          push_inst = imem_rsp_data_i;
          push_pc   = addr_q;
          kill_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (flush_i) begin
          kill_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Flush overrides any store or pop decided above in the same cycle.
    if (flush_i) push = 1'b0;
    pop = !flush_i && (count != '0) && inst_ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (latch_addr) addr_q <= pc_i;
      if (flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= push_inst;
      fifo_pc[wr_ptr]   <= push_pc;
      fifo_err[wr_ptr]  <= push_err;
    end
  end

  assign head_valid       = !rst && (count != '0);
  assign pc_ready_o       = !rst && pc_ready_int;
  assign imem_req_valid_o = !rst && req_valid_int;
  assign imem_req_addr_o  = rst ? '0 : addr_q;
  assign inst_valid_o     = head_valid;
  assign inst_o           = head_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc_o        = head_valid ? fifo_pc[rd_ptr]   : '0;
  assign inst_err_o       = head_valid ? fifo_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: hand-computed expectations checked with
// immediate assertions, inputs driven just after each rising edge.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_err_o(inst_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Zero-wait aligned fetch: accept, request handshake, response.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    pc_valid_i = 1'b1; pc_i = pc; settle();
    tick();
    pc_valid_i = 1'b0; imem_req_ready_i = 1'b1; settle();
    tick();
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = data; settle();
    tick();
    imem_rsp_valid_i = 1'b0; settle();
  endtask

  task automatic pop_one();
    inst_ready_i = 1'b1; settle();
    tick();
    inst_ready_i = 1'b0; settle();
  endtask

  task automatic chk_head(input string tag, input logic [31:0] inst, input logic [31:0] pc, input logic err);
    chk({tag, "_valid"}, inst_valid_o, 1'b1);
    chk({tag, "_inst"},  inst_o, inst);
    chk({tag, "_pc"},    inst_pc_o, pc);
    chk({tag, "_err"},   inst_err_o, err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_ready"},  pc_ready_o, 1'b0);
    chk({tag, "_req_valid"}, imem_req_valid_o, 1'b0);
    chk({tag, "_req_addr"},  imem_req_addr_o, 32'h0);
    chk({tag, "_inst_valid"}, inst_valid_o, 1'b0);
    chk({tag, "_inst"},      inst_o, 32'h0);
    chk({tag, "_inst_pc"},   inst_pc_o, 32'h0);
    chk({tag, "_err"},       inst_err_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    inst_ready_i = 1'b0;

    // Reset: two cycles, everything low
    tick();
    chk_all_zero("rst");
    tick();
    rst = 1'b0; settle();
    chk("post_rst_pc_ready", pc_ready_o, 1'b1);
    chk("post_rst_inst_valid", inst_valid_o, 1'b0);

    // 1: zero-wait fetch latency t+1 request, t+3 instruction
    pc_valid_i = 1'b1; pc_i = 32'h0; settle();
    chk("t1_accept", pc_ready_o, 1'b1);
    tick();
    pc_valid_i = 1'b0; settle();
    chk("t1_req_valid", imem_req_valid_o, 1'b1);
    chk("t1_req_addr", imem_req_addr_o, 32'h0);
    chk("t1_busy_ready", pc_ready_o, 1'b0);
    imem_req_ready_i = 1'b1; settle();
    tick();
    imem_req_ready_i = 1'b0; settle();
    chk("t1_req_done", imem_req_valid_o, 1'b0);
    chk("t1_not_yet", inst_valid_o, 1'b0);
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0013; settle();
    tick();
    imem_rsp_valid_i = 1'b0; settle();
    chk_head("t1_head", 32'h0000_0013, 32'h0, 1'b0);
    pop_one();
    chk("t1_empty", inst_valid_o, 1'b0);

    // 2: two entries buffered, third pc blocked until a pop, order kept
    fetch(32'h0, 32'h0000_0100);
    chk("t2_ready_1", pc_ready_o, 1'b1);
    fetch(32'h4, 32'h0000_0104);
    pc_valid_i = 1'b1; pc_i = 32'h8; settle();
    chk("t2_full_ready", pc_ready_o, 1'b0);
    tick();
    chk("t2_no_req", imem_req_valid_o, 1'b0);
    chk("t2_still_full", pc_ready_o, 1'b0);
    chk_head("t2_head0", 32'h0000_0100, 32'h0, 1'b0);
    pc_valid_i = 1'b0;
    pop_one();
    chk_head("t2_head1", 32'h0000_0104, 32'h4, 1'b0);
    chk("t2_ready_after_pop", pc_ready_o, 1'b1);
    fetch(32'h8, 32'h0000_0108);
    chk_head("t2_head1b", 32'h0000_0104, 32'h4, 1'b0);
    pop_one();
    chk_head("t2_head2", 32'h0000_0108, 32'h8, 1'b0);
    pop_one();
    chk("t2_empty", inst_valid_o, 1'b0);

    // 3: misaligned pc faults at t+1, no memory request
    pc_valid_i = 1'b1; pc_i = 32'h6; settle();
    chk("t3_accept", pc_ready_o, 1'b1);
    tick();
    pc_valid_i = 1'b0; settle();
    chk_head("t3_head", 32'h0, 32'h6, 1'b1);
    chk("t3_no_req", imem_req_valid_o, 1'b0);
    chk("t3_ready", pc_ready_o, 1'b1);
    pop_one();
    chk("t3_empty", inst_valid_o, 1'b0);

    // 4: request stalled 3 cycles, flush during REQ, response dropped
    pc_valid_i = 1'b1; pc_i = 32'h10; settle();
    tick();
    pc_valid_i = 1'b0; settle();
    chk("t4_req_c1", imem_req_valid_o, 1'b1);
    chk("t4_addr_c1", imem_req_addr_o, 32'h10);
    tick();
    flush_i = 1'b1; settle();
    chk("t4_addr_c2", imem_req_addr_o, 32'h10);
    chk("t4_flush_ready", pc_ready_o, 1'b0);
    tick();
    flush_i = 1'b0; settle();
    chk("t4_req_c3", imem_req_valid_o, 1'b1);
    chk("t4_addr_c3", imem_req_addr_o, 32'h10);
    tick();
    imem_req_ready_i = 1'b1; settle();
    chk("t4_addr_c4", imem_req_addr_o, 32'h10);
    tick();
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF; settle();
    tick();
    imem_rsp_valid_i = 1'b0; settle();
    chk("t4_dropped", inst_valid_o, 1'b0);
    chk("t4_ready_back", pc_ready_o, 1'b1);
    chk("t4_idle", imem_req_valid_o, 1'b0);
    tick();
    chk("t4_still_empty", inst_valid_o, 1'b0);

    // 5: flush with a pop and a response together leaves FIFO empty
    fetch(32'h20, 32'h0000_0200);
    pc_valid_i = 1'b1; pc_i = 32'h24; settle();
    tick();
    pc_valid_i = 1'b0; imem_req_ready_i = 1'b1; settle();
    tick();
    imem_req_ready_i = 1'b0;
    flush_i = 1'b1; inst_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0300; settle();
    tick();
    flush_i = 1'b0; inst_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; settle();
    chk("t5_empty", inst_valid_o, 1'b0);
    chk("t5_ready", pc_ready_o, 1'b1);
    fetch(32'h28, 32'h0000_0400);
    chk_head("t5_refetch", 32'h0000_0400, 32'h28, 1'b0);
    pop_one();

    // 6: reset while waiting, stray response ignored, fetch restarts
    fetch(32'h2C, 32'h0000_0500);
    pc_valid_i = 1'b1; pc_i = 32'h30; settle();
    tick();
    pc_valid_i = 1'b0; imem_req_ready_i = 1'b1; settle();
    tick();
    imem_req_ready_i = 1'b0; rst = 1'b1; settle();
    tick();
    chk_all_zero("t6_rst");
    rst = 1'b0; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0555; settle();
    tick();
    imem_rsp_valid_i = 1'b0; settle();
    chk("t6_stray_ignored", inst_valid_o, 1'b0);
    chk("t6_ready", pc_ready_o, 1'b1);
    fetch(32'h34, 32'h0000_0600);
    chk_head("t6_restart", 32'h0000_0600, 32'h34, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
